// File: rtl/async_transmitter_pkg.sv
// Shared UART definitions: frame state encoding and the baud increment helper.
// Also supplies fallback values for the UART_CLK / UART_BAUD build macros.
`ifndef UART_CLK
`define UART_CLK 25000000
`endif
`ifndef UART_BAUD
`define UART_BAUD 115200
`endif

package async_transmitter_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    B0    = 4'd2,
    B1    = 4'd3,
    B2    = 4'd4,
    B3    = 4'd5,
    B4    = 4'd6,
    B5    = 4'd7,
    B6    = 4'd8,
    B7    = 4'd9,
    PAR   = 4'd10,
    STOP  = 4'd11
  } txState_t;

  // Rounded fractional step so that the accumulator carries once per
  // (bit period >> ovsLog2).
  function automatic int unsigned baudInc(input longint unsigned clkFreq,
                                          input longint unsigned baud,
                                          input int unsigned     accWidth,
                                          input int unsigned     ovsLog2);
    longint unsigned num;
    num = (baud << (accWidth - 4 + ovsLog2)) + (clkFreq >> 5);
    return int'(num / (clkFreq >> 4));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud accumulator; tick is the registered carry out.
module uart_baud_tick
  import async_transmitter_pkg::*;
#(
  parameter int unsigned ClkFrequency   = `UART_CLK,
  parameter int unsigned Baud           = `UART_BAUD,
  parameter int unsigned AccWidth       = 16,
  parameter int unsigned OversampleLog2 = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned Inc = baudInc(ClkFrequency, Baud, AccWidth, OversampleLog2);

  logic [AccWidth:0] acc;
  logic [AccWidth:0] base;

  // clr drops the carried history; en adds a step on top of it, so a clear
  // and a first step can happen in the same cycle.
  assign base = clr ? '0 : {1'b0, acc[AccWidth-1:0]};

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else       acc <= base + (en ? (AccWidth+1)'(Inc) : '0);
  end

  assign tick = acc[AccWidth];

endmodule

// File: rtl/async_transmitter.sv
// 8N1 RS-232 transmitter, LSB first, registered TxD.
// Build option UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
module async_transmitter
  import async_transmitter_pkg::*;
#(
  parameter int unsigned ClkFrequency          = `UART_CLK,
  parameter int unsigned Baud                  = `UART_BAUD,
  parameter int unsigned BaudGeneratorAccWidth = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy,
  output logic       TxD_done
);

  txState_t   state, nextState;
  logic [7:0] dataReg;
  logic       baudTick, accept, nextTxd;
  logic [2:0] bitIdx;

  assign accept   = (state == IDLE) && TxD_start;
  assign TxD_busy = (state != IDLE);

  // The accept cycle already counts toward the start bit, which together
  // with the one-cycle register delay makes the start bit a full period.
  uart_baud_tick #(
    .ClkFrequency  (ClkFrequency),
    .Baud          (Baud),
    .AccWidth      (BaudGeneratorAccWidth),
    .OversampleLog2(0)
  ) baudGen (
    .clk  (clk),
    .reset(reset),
    .clr  (state == IDLE),
    .en   (TxD_busy || accept),
    .tick (baudTick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (TxD_start) nextState = START;
      START:   if (baudTick)  nextState = B0;
`ifdef UART_TX_PARITY_EN
      B7:      if (baudTick)  nextState = PAR;
`else
      B7:      if (baudTick)  nextState = STOP;
`endif
      STOP:    if (baudTick)  nextState = IDLE;
      default: if (baudTick)  nextState = txState_t'(state + 4'd1);
    endcase
  end

  assign bitIdx = 3'(nextState - B0);

  // Line level is derived from the state being entered so TxD changes on
  // the same edge as the state.
  always_comb begin
    nextTxd = 1'b1;
    if (nextState == START)
      nextTxd = 1'b0;
    else if (nextState >= B0 && nextState <= B7)
      nextTxd = dataReg[bitIdx];
`ifdef UART_TX_PARITY_EN
    else if (nextState == PAR)
      nextTxd = ^dataReg;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      TxD      <= 1'b1;
      TxD_done <= 1'b0;
      dataReg  <= '0;
    end else begin
      TxD      <= nextTxd;
      TxD_done <= (state == STOP) && baudTick;
      if (accept) dataReg <= TxD_data;
    end
  end

endmodule

// File: tb/tb_async_transmitter.sv
// Bench for async_transmitter: cycle-exact frame table plus a line decoder scoreboard.
// Honours UART_TX_PARITY_EN to match the DUT build.
module tb_async_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BP = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       TxD_start = 1'b0;
  logic [7:0] TxD_data = 8'h00;
  logic       TxD, TxD_busy, TxD_done;

  int tests = 0;
  int fails = 0;
  int rxFrames = 0;
  logic monEn = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[6];
  vec_t sbq[$];

  always #5 clk = ~clk;

  async_transmitter #(
    .ClkFrequency(1600000),
    .Baud(100000),
    .BaudGeneratorAccWidth(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .TxD_start(TxD_start),
    .TxD_data(TxD_data),
    .TxD(TxD),
    .TxD_busy(TxD_busy),
    .TxD_done(TxD_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line decoder: samples mid-bit and scores against the expected queue.
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    logic       p;
    vec_t       e;
    prev = 1'b1;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (monEn && prev === 1'b1 && TxD === 1'b0) begin
        repeat (7) @(negedge clk);
        check("rx_start", 32'(TxD), 0);
        for (int k = 0; k < 8; k++) begin
          repeat (BP) @(negedge clk);
          b[k] = TxD;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BP) @(negedge clk);
        p = TxD;
`endif
        repeat (BP) @(negedge clk);
        check("rx_stop", 32'(TxD), 1);
        rxFrames++;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got frame %0h expected none", b);
        end else begin
          e = sbq.pop_front();
          check("rx_data", 32'(b), 32'(e.data));
`ifdef UART_TX_PARITY_EN
          check("rx_par", 32'(p), 32'(e.par));
`endif
        end
      end
      prev = TxD;
    end
  end

  // Pulse start for one cycle (cycle 0) and check every cycle of the frame.
  task automatic runFrame(input vec_t v);
    logic [NB-1:0] bits;
    logic [2:0]    exp;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = v.data[k];
`ifdef UART_TX_PARITY_EN
    bits[9] = v.par;
`endif
    bits[NB-1] = 1'b1;
    sbq.push_back(v);
    @(posedge clk); #1 TxD_start = 1'b1; TxD_data = v.data;
    @(posedge clk); #1 TxD_start = 1'b0; TxD_data = 8'($urandom);
    for (int c = 1; c <= NB*BP + 3; c++) begin
      @(negedge clk);
      if (c <= NB*BP) exp = {bits[(c-1)/BP], 1'b1, 1'b0};
      else            exp = {1'b1, 1'b0, (c == NB*BP + 1)};
      check($sformatf("frame_%h_cyc%0d {TxD,busy,done}", v.data, c),
            32'({TxD, TxD_busy, TxD_done}), 32'(exp));
    end
  endtask

  task automatic waitDone(input int maxCyc, output logic got);
    got = 1'b0;
    for (int i = 0; i < maxCyc && !got; i++) begin
      @(negedge clk);
      got = TxD_done;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1 ms");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   rx0, cnt;
    logic got;

    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h00, par: 1'b0};
    vecs[2] = '{data: 8'hFF, par: 1'b0};
    vecs[3] = '{data: 8'h07, par: 1'b1};
    vecs[4] = '{data: 8'h03, par: 1'b0};
    vecs[5] = '{data: 8'h81, par: 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle {TxD,busy,done}", 32'({TxD, TxD_busy, TxD_done}), 32'(3'b100));
    end

    foreach (vecs[i]) runFrame(vecs[i]);

    // Start held high across two frames; data changed while busy.
    rx0 = rxFrames;
    sbq.push_back('{data: 8'h00, par: 1'b0});
    sbq.push_back('{data: 8'hFF, par: 1'b0});
    @(posedge clk); #1 TxD_start = 1'b1; TxD_data = 8'h00;
    @(posedge clk); #1 TxD_data = 8'hFF;
    waitDone(400, got);
    check("b2b_done1", 32'(got), 1);
    @(negedge clk);
    check("b2b_gap_txd", 32'(TxD), 0);
    check("b2b_gap_busy", 32'(TxD_busy), 1);
    @(posedge clk); #1 TxD_start = 1'b0;
    waitDone(400, got);
    check("b2b_done2", 32'(got), 1);
    repeat (4) @(negedge clk);
    check("b2b_frames", 32'(rxFrames - rx0), 2);
    check("b2b_sb_empty", 32'(sbq.size()), 0);

    // Request mid-frame is ignored.
    rx0 = rxFrames;
    sbq.push_back('{data: 8'h5A, par: 1'b0});
    @(posedge clk); #1 TxD_start = 1'b1; TxD_data = 8'h5A;
    @(posedge clk); #1 TxD_start = 1'b0;
    repeat (50) @(posedge clk);
    #1 TxD_start = 1'b1; TxD_data = 8'hC3;
    @(posedge clk); #1 TxD_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (TxD_done) cnt++;
    end
    check("mid_done_count", 32'(cnt), 1);
    check("mid_frames", 32'(rxFrames - rx0), 1);
    check("mid_sb_empty", 32'(sbq.size()), 0);

    // Reset during B3 of 8'h3C, with start asserted in the same cycle.
    monEn = 1'b0;
    @(posedge clk); #1 TxD_start = 1'b1; TxD_data = 8'h3C;
    @(posedge clk); #1 TxD_start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("rst_pre_busy", 32'(TxD_busy), 1);
    check("rst_pre_b3", 32'(TxD), 1);
    reset = 1'b1; TxD_start = 1'b1; TxD_data = 8'hFF;
    @(posedge clk); #1 reset = 1'b0; TxD_start = 1'b0;
    @(negedge clk);
    check("rst_txd", 32'(TxD), 1);
    check("rst_busy", 32'(TxD_busy), 0);
    check("rst_done", 32'(TxD_done), 0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (TxD_done || TxD_busy || !TxD) cnt++;
    end
    check("rst_quiet_cycles", 32'(cnt), 0);
    monEn = 1'b1;
    runFrame('{data: 8'h3C, par: 1'b0});
    repeat (4) @(negedge clk);
    check("final_sb_empty", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
